// File: rtl/pc_fetch_gen_pkg.sv
// pc_fetch_gen_pkg -- shared definitions for the instruction fetch PC generator.
//   DEFAULT_RESET_VECTOR : default first fetch address
//   EXC_BIT_*            : bit positions inside excepttype_o
//   ST_*                 : fetch FSM state encoding
//   inst_addr_increment  : bytes covered by one fetch block (InstAddrIncrement)
package pc_fetch_gen_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hbfc00000;

   localparam int EXC_BIT_REFILL  = 16;
   localparam int EXC_BIT_ADEL    = 17;
   localparam int EXC_BIT_INVALID = 19;

   localparam logic [1:0] ST_BOOT      = 2'd0;
   localparam logic [1:0] ST_FETCH     = 2'd1;
   localparam logic [1:0] ST_EXC_DRAIN = 2'd2;
   localparam logic [1:0] ST_EXC_HOLD  = 2'd3;

   // Bytes spanned by one fetch block of fetch_w 32-bit instructions.
   function automatic int unsigned inst_addr_increment(input int unsigned fetch_w);
      return fetch_w * 32'd4;
   endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if -- fetch request/response bus between the PC generator
// (master) and the instruction memory side (slave).
//   req_o / inst_vaddr_o / lane_mask_o : request from the PC generator
//   addr_ok                            : request accepted this cycle
//   data_ok                            : oldest outstanding request answered
//   inst_paddr_refill_i/invalid_i      : translation fault of the current request
interface pc_fetch_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int FETCH_W = 2
);
   logic               req_o;
   logic [ADDR_W-1:0]  inst_vaddr_o;
   logic [FETCH_W-1:0] lane_mask_o;
   logic               addr_ok;
   logic               data_ok;
   logic               inst_paddr_refill_i;
   logic               inst_paddr_invalid_i;

   modport master (
      output req_o, inst_vaddr_o, lane_mask_o,
      input  addr_ok, data_ok, inst_paddr_refill_i, inst_paddr_invalid_i
   );

   modport slave (
      input  req_o, inst_vaddr_o, lane_mask_o,
      output addr_ok, data_ok, inst_paddr_refill_i, inst_paddr_invalid_i
   );
endinterface

// File: rtl/pc_fetch_gen_pc_fifo.sv
// pc_fifo -- synchronous FIFO holding the attributes of accepted fetch
// requests until their data returns.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push     : write wdata at the tail
//   pop      : drop the head entry
//   wdata    : entry to write
//   rdata    : current head entry
// The owner never pushes beyond DEPTH outstanding entries nor pops when empty,
// so no full/empty flags are kept.
module pc_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 36
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;

   // Pointer advance with wrap for depths that are not a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Storage and pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
      end
   end

   assign rdata = mem_r[rd_ptr_r];

endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen -- instruction fetch PC generator with outstanding-request
// tracking, redirect (branch / flush) handling and response tagging.
//   clk, rst                 : clock, asynchronous active-high reset
//   stall                    : blocks issue of a new request
//   flush, new_pc            : redirect to new_pc and discard outstanding responses
//   branch_flag_i, branch_target_address_i : taken branch from decode
//   bus (master)             : request / accept / data handshake, translation faults
//   resp_valid_o, resp_pc_o, resp_lane_mask_o, excepttype_o : tagged response
// Optional feature macro PC_ADEL_CHECK_EN: a misaligned PC raises an AdEL
// pseudo-response after outstanding requests drain, then waits for a flush.
// Without it the low two PC bits are forced to zero on the request address.
module pc_fetch_gen
   import pc_fetch_gen_pkg::*;
#(
   parameter int                 ADDR_W       = 32,
   parameter int                 FETCH_W      = 2,
   parameter int                 MAX_OUT      = 2,
   parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  new_pc,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_address_i,
   pc_fetch_gen_if.master     bus,
   output logic               resp_valid_o,
   output logic [ADDR_W-1:0]  resp_pc_o,
   output logic [FETCH_W-1:0] resp_lane_mask_o,
   output logic [31:0]        excepttype_o
);
   localparam int                CNT_W    = 3;
   localparam int                FIFO_W   = ADDR_W + FETCH_W + 2;
   localparam logic [ADDR_W-1:0] BLK      = ADDR_W'(inst_addr_increment(FETCH_W));
   localparam logic [ADDR_W-1:0] BLK_MASK = ~(BLK - ADDR_W'(1));
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);

   logic [1:0]         state_r, state_next_s;
   logic [ADDR_W-1:0]  pc_r, pc_next_s;
   logic               hold_r;
   logic               pend_valid_r, pend_flush_r;
   logic [ADDR_W-1:0]  pend_pc_r;
   logic [CNT_W-1:0]   cnt_r, cnt_next_s;
   logic [CNT_W-1:0]   disc_r, disc_next_s;
   logic               req_s, accept_s, pop_s;
   logic               misaligned_s, adel_emit_s, resp_valid_s;
   logic [ADDR_W-1:0]  vaddr_s;
   logic [1:0]         lane_idx_s;
   logic [FETCH_W-1:0] mask_s;
   logic [FIFO_W-1:0]  push_data_s, head_s;

`ifdef PC_ADEL_CHECK_EN
   assign misaligned_s = (pc_r[1:0] != 2'b00);
   assign vaddr_s      = pc_r;
`else
   assign misaligned_s = 1'b0;
   assign vaddr_s      = {pc_r[ADDR_W-1:2], 2'b00};
`endif

   // A held request stays up regardless of stall until it is accepted.
   assign req_s    = (state_r == ST_FETCH) &&
                     (hold_r || (!stall && (cnt_r < MAX_CNT) && !pend_valid_r && !misaligned_s));
   assign accept_s = req_s && bus.addr_ok;
   assign pop_s    = bus.data_ok && (cnt_r != {CNT_W{1'b0}});

   // AdEL pseudo-response fires once the pipe is empty, unless a flush redirects first.
   assign adel_emit_s  = (state_r == ST_EXC_DRAIN) && (cnt_r == {CNT_W{1'b0}}) && !flush;
   assign resp_valid_s = (pop_s && (disc_r == {CNT_W{1'b0}})) || adel_emit_s;

   // Lane mask: lanes before the PC's slot inside the block are invalid.
   always_comb begin
      lane_idx_s = pc_r[3:2] & 2'(FETCH_W - 1);
      mask_s     = {FETCH_W{1'b0}};
      for (int i = 0; i < FETCH_W; i++) begin
         mask_s[i] = (2'(i) >= lane_idx_s);
      end
   end

   // Next-state and next-PC selection.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      case (state_r)
         ST_BOOT: begin
            state_next_s = ST_FETCH;
         end
         ST_FETCH: begin
            if (accept_s) begin
               if (pend_valid_r)       pc_next_s = pend_pc_r;
               else if (flush)         pc_next_s = new_pc;
               else if (branch_flag_i) pc_next_s = branch_target_address_i;
               else                    pc_next_s = (pc_r & BLK_MASK) + BLK;
            end else if (!req_s) begin
               if (flush)              pc_next_s = new_pc;
               else if (misaligned_s)  state_next_s = ST_EXC_DRAIN;
               else if (branch_flag_i) pc_next_s = branch_target_address_i;
               else                    pc_next_s = pc_r;
            end else begin
               // Request waiting for addr_ok: redirects go to the pending register.
               pc_next_s = pc_r;
            end
         end
         ST_EXC_DRAIN: begin
            if (flush) begin
               pc_next_s    = new_pc;
               state_next_s = ST_FETCH;
            end else if (cnt_r == {CNT_W{1'b0}}) begin
               state_next_s = ST_EXC_HOLD;
            end else begin
               state_next_s = ST_EXC_DRAIN;
            end
         end
         ST_EXC_HOLD: begin
            if (flush) begin
               pc_next_s    = new_pc;
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_EXC_HOLD;
            end
         end
         default: begin
            state_next_s = ST_BOOT;
         end
      endcase
   end

   // Outstanding and discard counters; flush discards everything in flight after this cycle.
   always_comb begin
      case ({accept_s, pop_s})
         2'b10:   cnt_next_s = cnt_r + 3'd1;
         2'b01:   cnt_next_s = cnt_r - 3'd1;
         default: cnt_next_s = cnt_r;
      endcase
      if (flush)                                   disc_next_s = cnt_next_s;
      else if (pop_s && (disc_r != {CNT_W{1'b0}})) disc_next_s = disc_r - 3'd1;
      else                                         disc_next_s = disc_r;
   end

   // FSM state, PC, request hold flag and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_BOOT;
         pc_r    <= RESET_VECTOR;
         hold_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         disc_r  <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         pc_r    <= pc_next_s;
         hold_r  <= req_s && !accept_s;
         cnt_r   <= cnt_next_s;
         disc_r  <= disc_next_s;
      end
   end

   // Redirect arriving while a request waits for addr_ok; a flush is never overwritten by a branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid_r <= 1'b0;
         pend_flush_r <= 1'b0;
         pend_pc_r    <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         pend_valid_r <= 1'b0;
         pend_flush_r <= 1'b0;
      end else if (req_s && flush) begin
         pend_valid_r <= 1'b1;
         pend_flush_r <= 1'b1;
         pend_pc_r    <= new_pc;
      end else if (req_s && branch_flag_i && !pend_flush_r) begin
         pend_valid_r <= 1'b1;
         pend_pc_r    <= branch_target_address_i;
      end
   end

   assign push_data_s = {vaddr_s, mask_s, bus.inst_paddr_refill_i, bus.inst_paddr_invalid_i};

   pc_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (FIFO_W)
   ) u_pc_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept_s),
      .pop   (pop_s),
      .wdata (push_data_s),
      .rdata (head_s)
   );

   assign bus.req_o        = req_s;
   assign bus.inst_vaddr_o = req_s ? vaddr_s : {ADDR_W{1'b0}};
   assign bus.lane_mask_o  = req_s ? mask_s : {FETCH_W{1'b0}};

   // Response fields, zero whenever no response is presented.
   always_comb begin
      resp_pc_o        = {ADDR_W{1'b0}};
      resp_lane_mask_o = {FETCH_W{1'b0}};
      excepttype_o     = 32'h0000_0000;
      if (adel_emit_s) begin
         resp_pc_o                  = pc_r;
         resp_lane_mask_o           = mask_s;
         excepttype_o[EXC_BIT_ADEL] = 1'b1;
      end else if (resp_valid_s) begin
         resp_pc_o                     = head_s[FIFO_W-1 -: ADDR_W];
         resp_lane_mask_o              = head_s[2 +: FETCH_W];
         excepttype_o[EXC_BIT_REFILL]  = head_s[1];
         excepttype_o[EXC_BIT_INVALID] = head_s[0];
      end else begin
         resp_pc_o = {ADDR_W{1'b0}};
      end
   end

   assign resp_valid_o = resp_valid_s;

endmodule
